// File: rtl/urv_irq_unit.sv
// uRV machine-mode trap controller: parametrised IRQ count, per-IRQ edge/level select, MPIE stacking.
// Optional `URV_IRQ_VECTORED_EN: mtvec[0]=1 vectors interrupts to base + 4*code.

module urv_irq_line (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic edge_i,
  input  logic clr_i,
  output logic pend_o
);
  logic irq_q, sticky_q;

  // Sticky edge latch only tracks while in edge mode, so a mode switch starts clean.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      irq_q    <= irq_i;
      sticky_q <= edge_i ? ((sticky_q & ~clr_i) | (irq_i & ~irq_q)) : 1'b0;
    end
  end

  assign pend_o = edge_i ? sticky_q : irq_q;
endmodule

module urv_irq_unit #(
  parameter int          NUM_IRQS        = 8,
  parameter logic [31:0] RESET_MTVEC     = 32'h8,
  parameter logic [11:0] CSR_ID_MIRQEDGE = 12'h7C0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                x_stall_i,
  input  logic                x_kill_i,
  input  logic                d_is_csr_i,
  input  logic                d_is_eret_i,
  input  logic [11:0]         d_csr_sel_i,
  input  logic [31:0]         x_csr_write_value_i,
  input  logic [NUM_IRQS-1:0] exp_irq_i,
  input  logic                exp_tick_i,
  input  logic                exp_breakpoint_i,
  input  logic                exp_unaligned_load_i,
  input  logic                exp_unaligned_store_i,
  input  logic                exp_invalid_insn_i,
  input  logic [31:0]         x_exception_pc_i,
  output logic                x_exception_o,
  output logic [31:0]         x_exception_pc_o,
  output logic [31:0]         x_exception_vector_o,
  output logic [31:0]         csr_mstatus_o,
  output logic [31:0]         csr_mip_o,
  output logic [31:0]         csr_mie_o,
  output logic [31:0]         csr_mtvec_o,
  output logic [31:0]         csr_mepc_o,
  output logic [31:0]         csr_mcause_o,
  output logic [31:0]         csr_mirqedge_o
);
  localparam logic [11:0] ID_MSTATUS = 12'h300;
  localparam logic [11:0] ID_MIE     = 12'h304;
  localparam logic [11:0] ID_MTVEC   = 12'h305;
  localparam logic [11:0] ID_MEPC    = 12'h341;
  localparam logic [11:0] ID_MIP     = 12'h344;
  localparam logic [31:0] EXC_MASK   = 32'h0000_005C;
  localparam logic [31:0] IRQ_MASK   = ((32'h1 << NUM_IRQS) - 32'h1) << 16;
  localparam logic [31:0] INT_MASK   = IRQ_MASK | 32'h80;
`ifdef URV_IRQ_VECTORED_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic                adv, eret, trap_take, is_int;
  logic                wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mip, wr_edge;
  logic                ie_q, mpie_q, trap_active_q;
  logic [31:0]         mtvec_q, mepc_q, mcause_q, mie_q;
  logic [31:0]         mip_rd, mie_rd, pend_eff, en;
  logic [NUM_IRQS-1:0] mirqedge_q, irq_pend, line_clr;
  logic [7:0]          sticky_q, sticky_set, sticky_clr;
  logic [4:0]          cause;
  logic [31:0]         base;

  assign adv        = !x_stall_i && !x_kill_i;
  assign wr_mstatus = adv && d_is_csr_i && (d_csr_sel_i == ID_MSTATUS);
  assign wr_mie     = adv && d_is_csr_i && (d_csr_sel_i == ID_MIE);
  assign wr_mtvec   = adv && d_is_csr_i && (d_csr_sel_i == ID_MTVEC);
  assign wr_mepc    = adv && d_is_csr_i && (d_csr_sel_i == ID_MEPC);
  assign wr_mip     = adv && d_is_csr_i && (d_csr_sel_i == ID_MIP);
  assign wr_edge    = adv && d_is_csr_i && (d_csr_sel_i == CSR_ID_MIRQEDGE);

  assign mip_rd   = {16'(irq_pend), 8'h00, sticky_q & 8'hDC};
  assign mie_rd   = mie_q | EXC_MASK;
  // Illegal instruction requests a trap in its own cycle, ahead of its sticky bit.
  assign pend_eff = mip_rd | {29'b0, exp_invalid_insn_i, 2'b00};
  assign en       = (pend_eff & EXC_MASK) | (pend_eff & mie_rd & INT_MASK & {32{ie_q}});

  // Priority order coincides with ascending mip bit index.
  always_comb begin
    cause = '0;
    for (int b = 31; b >= 0; b--)
      if (en[b]) cause = 5'(b);
  end

  assign is_int        = (cause == 5'd7) || cause[4];
  assign x_exception_o = (|en) && !trap_active_q;
  assign eret          = adv && d_is_eret_i;
  assign trap_take     = adv && x_exception_o && !d_is_eret_i;

  always_comb begin
    sticky_set    = '0;
    sticky_set[2] = exp_invalid_insn_i && !(trap_take && cause == 5'd2);
    sticky_set[3] = exp_breakpoint_i;
    sticky_set[4] = exp_unaligned_load_i;
    sticky_set[6] = exp_unaligned_store_i;
    sticky_set[7] = exp_tick_i;
    sticky_clr    = '0;
    for (int b = 0; b < 8; b++)
      sticky_clr[b] = (trap_take && cause == 5'(b)) || (wr_mip && !x_csr_write_value_i[b]);
  end

  for (genvar n = 0; n < NUM_IRQS; n++) begin : g_line
    assign line_clr[n] = (trap_take && cause == 5'(16 + n)) ||
                         (wr_mip && !x_csr_write_value_i[16 + n]);
    urv_irq_line u_line (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .irq_i  (exp_irq_i[n]),
      .edge_i (mirqedge_q[n]),
      .clr_i  (line_clr[n]),
      .pend_o (irq_pend[n])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q      <= '0;
      ie_q          <= 1'b0;
      mpie_q        <= 1'b0;
      trap_active_q <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mie_q         <= '0;
      mtvec_q       <= RESET_MTVEC & MTVEC_MASK;
      mirqedge_q    <= '0;
    end else begin
      sticky_q <= ((sticky_q & ~sticky_clr) | sticky_set) & 8'hDC;
      if (eret) begin
        ie_q          <= mpie_q;
        mpie_q        <= 1'b1;
        trap_active_q <= 1'b0;
      end else if (trap_take) begin
        mpie_q        <= ie_q;
        ie_q          <= 1'b0;
        trap_active_q <= 1'b1;
      end else if (wr_mstatus) begin
        ie_q   <= x_csr_write_value_i[0];
        mpie_q <= x_csr_write_value_i[1];
      end
      if (trap_take) begin
        mepc_q   <= x_exception_pc_i;
        mcause_q <= {is_int, 26'b0, cause};
      end else if (wr_mepc) begin
        mepc_q <= x_csr_write_value_i;
      end
      if (wr_mie)   mie_q      <= x_csr_write_value_i & INT_MASK;
      if (wr_mtvec) mtvec_q    <= x_csr_write_value_i & MTVEC_MASK;
      if (wr_edge)  mirqedge_q <= x_csr_write_value_i[NUM_IRQS-1:0];
    end
  end

  assign base = {mtvec_q[31:2], 2'b00};
`ifdef URV_IRQ_VECTORED_EN
  assign x_exception_vector_o = (mtvec_q[0] && is_int) ? base + {25'b0, cause, 2'b00} : base;
`else
  assign x_exception_vector_o = base;
`endif

  assign x_exception_pc_o = mepc_q;
  assign csr_mstatus_o    = {30'b0, mpie_q, ie_q};
  assign csr_mip_o        = mip_rd;
  assign csr_mie_o        = mie_rd;
  assign csr_mtvec_o      = mtvec_q;
  assign csr_mepc_o       = mepc_q;
  assign csr_mcause_o     = mcause_q;
  assign csr_mirqedge_o   = 32'(mirqedge_q);
endmodule

// File: doc/urv_irq_unit.md
Name: urv_irq_unit

Overview:
- Parametrised machine-mode trap controller for uRV. Successor to the fixed 8-IRQ exception unit.
- Adds a configurable IRQ count and per-IRQ edge/level sensitivity.
- Adds MPIE stacking on trap/eret and an interrupt flag in mcause.
- Sits beside the execute stage: takes exception/IRQ sources and CSR writes, and drives the trap request, vector and saved PC to the fetch/execute redirect logic.

Parameters:
- NUM_IRQS, 8, number of external IRQ lines; legal range 1..16.
- RESET_MTVEC, 32'h8, reset value of mtvec.
- CSR_ID_MIRQEDGE, 12'h7C0, CSR address of the per-IRQ edge-select register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- x_stall_i  in  1  execute stage stalled
- x_kill_i  in  1  execute stage killed
- d_is_csr_i  in  1  CSR write instruction in execute
- d_is_eret_i  in  1  eret in execute
- d_csr_sel_i  in  12  CSR address
- x_csr_write_value_i  in  32  CSR write data
- exp_irq_i  in  NUM_IRQS  external IRQ lines
- exp_tick_i  in  1  timer tick
- exp_breakpoint_i, exp_unaligned_load_i, exp_unaligned_store_i, exp_invalid_insn_i  in  1 each  synchronous exception sources
- x_exception_pc_i  in  32  PC of the instruction in execute
- x_exception_o  out  1  take trap
- x_exception_pc_o  out  32  mepc
- x_exception_vector_o  out  32  trap target
- csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mirqedge_o  out  32 each  CSR read values

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous, active-high.
- Reset values: mtvec=RESET_MTVEC; all other CSRs and pending bits 0; trap_active=0; x_exception_o=0.
- adv = !x_stall_i && !x_kill_i. All CSR writes and all trap/eret state updates happen only on adv.
- mip bit map: illegal 2, breakpoint 3, unaligned load 4, unaligned store 6, timer 7, irq n at 16+n. Unused bits read 0.
- mie uses the same bit map. Bits 2,3,4,6 are hardwired 1. Bits 7 and 16+n are writable. Unused bits read 0.
- mstatus: bit0=IE, bit1=MPIE; all other bits read 0.
- Synchronous exceptions: the source pulse sets a sticky mip bit on the next edge, regardless of adv. The bit clears on the trap that reports it.
  - exp_invalid_insn_i also requests a trap combinationally in its own cycle.
- Timer: exp_tick_i sets sticky mip[7].
- IRQ sensitivity is chosen per line by mirqedge[n]:
  - Level (mirqedge[n]=0): mip[16+n] is exp_irq_i[n] registered once (1-cycle latency).
  - Edge (mirqedge[n]=1): a rising edge (registered previous value, low to high) sets sticky mip[16+n].
- Clearing pending bits: a CSR write to mip on adv clears sticky bits written 0; writing 1 has no effect. The write and a same-cycle set: the set wins.
- Enable: interrupt bit b is enabled when mip[b] & mie[b] & IE. Exception bits are always enabled.
- Priority (first match wins): illegal, breakpoint, unaligned load, unaligned store, timer, irq0..irq(NUM_IRQS-1).
- Trap request: x_exception_o = any enabled pending & !trap_active.
- Trap taken on adv && x_exception_o:
  - mepc<=x_exception_pc_i
  - mcause[31] <= 1 if the cause is an interrupt; mcause[4:0] <= code (mip bit index)
  - MPIE<=IE, IE<=0, trap_active<=1
- eret on adv: IE<=MPIE, MPIE<=1, trap_active<=0.
- Same cycle as eret: eret wins and no trap is taken; a still-pending source traps on the next adv cycle.
- CSR write in the same cycle as a trap: trap updates to mepc, mcause and IE take priority; other CSRs write normally.
- CSR writes to mtvec, mepc, mie, mstatus and mirqedge on adv. mirqedge bits at NUM_IRQS and above read 0.
- x_exception_vector_o = {mtvec[31:2],2'b00} unless the optional feature is enabled.
- x_exception_pc_o = mepc.
- Reset mid-trap: all state returns to reset values on the next edge; in-flight pending bits are lost.

Optional Feature:
- URV_IRQ_VECTORED_EN defined:
  - mtvec[0]=1 selects vectored mode: interrupts vector to base + 4*code; exceptions use base.
  - mtvec[1:0] is writable.
- Macro absent: mtvec[1:0] reads 0, vector is always base, and no adder is generated.

Test Plan:
- Reset, then read CSRs -> mtvec=0x8, mstatus=0, mip=0, x_exception_o=0.
- IE=1, mie[16]=1, level IRQ0 held high from cycle 0 -> x_exception_o=1 in cycle 1; mcause=0x80000010; mepc=PC; IE=0; MPIE=1. eret -> IE=1 and a re-trap on the next adv while the line is still high.
- mirqedge[2]=1, a 1-cycle IRQ2 pulse while IE=0 -> mip[18] stays 1. Set IE=1 -> trap, mcause=0x80000012. Write mip=0 -> bit clears.
- Invalid insn and IRQ0 pending in the same cycle -> mcause=2; the IRQ traps after eret.
- eret and breakpoint in the same adv cycle -> no trap that cycle; trap with mcause=3 on the next adv; x_stall_i=1 holds mepc unchanged.
- With URV_IRQ_VECTORED_EN: mtvec=0x1001, timer trap -> vector=0x101C; illegal insn -> vector=0x1000.
